bus_ctrl6502: RTL and testbench

BUS_CTRL6502 -- requirements
Module: bus_ctrl6502

---
 rtl/bus_ctrl6502.sv | 177 +++++++++++++++++
 tb/tb_bus_ctrl6502.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl6502.sv
// 6502 bus controller: decodes RAM/IO/ROM regions, inserts ROM wait states and
// stretches IO cycles until io_ack or a timeout, stalling the CPU via cpu_ready.
module bus_ctrl6502 #(
  parameter int         ROM_WAIT   = 2,
  parameter logic [7:0] IO_TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        bus_err,
  output logic        rom_wr_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ROM, WAIT_IO} state_t;
  typedef enum logic [1:0] {RGN_RAM, RGN_IO, RGN_ROM} region_t;

  localparam int RomWaitM1 = (ROM_WAIT > 0) ? ROM_WAIT - 1 : 0;

  state_t      r_state;
  region_t     r_region;
  logic        r_write;
  logic [2:0]  r_romCnt;
  logic [7:0]  r_ioCnt;
  logic [7:0]  r_data;

  state_t      w_nextState;
  region_t     w_nextRegion;
  region_t     w_decRegion;
  region_t     w_region;
  logic        w_nextWrite;
  logic        w_write;
  logic [2:0]  w_nextRomCnt;
  logic [7:0]  w_nextIoCnt;
  logic        w_done;
  logic        w_timeout;

  assign mem_addr  = cpu_address;
  assign mem_wdata = cpu_data_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_region <= RGN_RAM;
      r_write  <= 1'b0;
      r_romCnt <= 3'd0;
      r_ioCnt  <= 8'd0;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_nextState;
      r_region <= w_nextRegion;
      r_write  <= w_nextWrite;
      r_romCnt <= w_nextRomCnt;
      r_ioCnt  <= w_nextIoCnt;
      if (w_done) r_data <= cpu_data_i;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextRegion = r_region;
    w_nextWrite  = r_write;
    w_nextRomCnt = r_romCnt;
    w_nextIoCnt  = r_ioCnt;
    w_region     = r_region;
    w_write      = r_write;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    cpu_ready    = 1'b0;
    cpu_data_i   = r_data;
    mem_we       = 1'b0;
    ram_cs       = 1'b0;
    rom_cs       = 1'b0;
    io_cs        = 1'b0;
    bus_err      = 1'b0;
    rom_wr_err   = 1'b0;

    if (cpu_address < 16'hD000)        w_decRegion = RGN_RAM;
    else if (cpu_address[15:12] == 4'hD) w_decRegion = RGN_IO;
    else                               w_decRegion = RGN_ROM;

    case (r_state)
      IDLE: begin
        // A new access starts here every cycle; decode live, latch for later.
        w_region     = w_decRegion;
        w_write      = cpu_write;
        w_nextRegion = w_decRegion;
        w_nextWrite  = cpu_write;
        case (w_decRegion)
          RGN_ROM: begin
            if (ROM_WAIT == 0) begin
              w_done = 1'b1;
            end else begin
              w_nextState  = WAIT_ROM;
              w_nextRomCnt = 3'(RomWaitM1);
            end
          end
          RGN_IO: begin
            if (io_ack) begin
              w_done = 1'b1;
            end else begin
              w_nextState = WAIT_IO;
              w_nextIoCnt = 8'd1;
            end
          end
          default: w_done = 1'b1;
        endcase
      end
      WAIT_ROM: begin
        if (r_romCnt == 3'd0) begin
          w_done      = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextRomCnt = r_romCnt - 3'd1;
        end
      end
      WAIT_IO: begin
        // r_ioCnt holds the offset of this cycle from the access start.
        if (io_ack) begin
          w_done      = 1'b1;
          w_nextState = IDLE;
        end else if (r_ioCnt == IO_TIMEOUT) begin
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextIoCnt = r_ioCnt + 8'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase

    cpu_ready  = w_done;
    ram_cs     = (w_region == RGN_RAM);
    rom_cs     = (w_region == RGN_ROM);
    io_cs      = (w_region == RGN_IO);
    mem_we     = w_done && w_write && !w_timeout && (w_region != RGN_ROM);
    bus_err    = w_timeout;
    rom_wr_err = w_done && w_write && (w_region == RGN_ROM);

    if (w_done) begin
      if (w_timeout) cpu_data_i = 8'hFF;
      else begin
        case (w_region)
          RGN_ROM: cpu_data_i = rom_rdata;
          RGN_IO:  cpu_data_i = io_rdata;
          default: cpu_data_i = ram_rdata;
        endcase
      end
    end

    if (reset) begin
      cpu_ready  = 1'b1;
      cpu_data_i = 8'h00;
      mem_we     = 1'b0;
      ram_cs     = 1'b0;
      rom_cs     = 1'b0;
      io_cs      = 1'b0;
      bus_err    = 1'b0;
      rom_wr_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_ctrl6502.sv
// Scoreboard bench for bus_ctrl6502: the driver queues hand-computed expectations,
// the negedge monitor accumulates per-access observations and compares on completion.
module tb_bus_ctrl6502;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_address = 16'h0000;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_data_o = 8'h00;
  logic [7:0]  cpu_data_i;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        ram_cs, rom_cs, io_cs;
  logic [7:0]  ram_rdata = 8'h3C;
  logic [7:0]  rom_rdata = 8'h00;
  logic [7:0]  io_rdata = 8'h00;
  logic        io_ack = 1'b0;
  logic        bus_err, rom_wr_err;

  bus_ctrl6502 #(.ROM_WAIT(2), .IO_TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_data_o(cpu_data_o),
    .cpu_data_i(cpu_data_i), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ram_cs(ram_cs), .rom_cs(rom_cs), .io_cs(io_cs),
    .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .io_rdata(io_rdata),
    .io_ack(io_ack), .bus_err(bus_err), .rom_wr_err(rom_wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] expData;
    int         expCycles;
    int         expWe;
    logic [7:0] expWdata;
    int         expBusErr;
    int         expRomErr;
    logic [2:0] expCs;
  } exp_t;

  exp_t sbQ[$];
  int compared = 0;
  int mismatched = 0;

  logic       txnActive = 1'b0;
  int         cycCnt = 0, weCnt = 0, busCnt = 0, romCnt = 0;
  logic [7:0] lastWdata = 8'h00;
  logic [7:0] heldModel = 8'h00;
  logic       csBad = 1'b0, holdBad = 1'b0, weEarly = 1'b0, passBad = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: observes every cycle of an active access and scores it on cpu_ready.
  always @(negedge clk) begin
    if (reset) begin
      heldModel = 8'h00;
    end else if (!txnActive) begin
      if (cpu_ready) heldModel = ram_rdata;
    end else if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_t e;
      cycCnt++;
      if (mem_we) begin
        weCnt++;
        lastWdata = mem_wdata;
        if (!cpu_ready) weEarly = 1'b1;
      end
      if (bus_err) busCnt++;
      if (rom_wr_err) romCnt++;
      if ({ram_cs, rom_cs, io_cs} !== sbQ[0].expCs) csBad = 1'b1;
      if (mem_addr !== cpu_address || mem_wdata !== cpu_data_o) passBad = 1'b1;
      if (!cpu_ready && cpu_data_i !== heldModel) holdBad = 1'b1;
      if (cpu_ready) begin
        e = sbQ.pop_front();
        checkOutput({e.name, "_cycles"}, cycCnt, e.expCycles);
        checkOutput({e.name, "_data"}, {24'd0, cpu_data_i}, {24'd0, e.expData});
        checkOutput({e.name, "_weCount"}, weCnt, e.expWe);
        if (e.expWe > 0) checkOutput({e.name, "_wdata"}, {24'd0, lastWdata}, {24'd0, e.expWdata});
        checkOutput({e.name, "_busErr"}, busCnt, e.expBusErr);
        checkOutput({e.name, "_romWrErr"}, romCnt, e.expRomErr);
        checkOutput({e.name, "_chipSel"}, {31'd0, csBad}, 32'd0);
        checkOutput({e.name, "_heldData"}, {31'd0, holdBad}, 32'd0);
        checkOutput({e.name, "_weEarly"}, {31'd0, weEarly}, 32'd0);
        checkOutput({e.name, "_passThru"}, {31'd0, passBad}, 32'd0);
        heldModel = e.expData;
        cycCnt = 0; weCnt = 0; busCnt = 0; romCnt = 0;
        csBad = 1'b0; holdBad = 1'b0; weEarly = 1'b0; passBad = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [15:0] addr, input logic wr,
                               input logic [7:0] wd, input logic [7:0] rd, input int ackDelay,
                               input logic [7:0] expData, input int expCycles, input int expWe,
                               input int expBus, input int expRom, input logic [2:0] expCs);
    exp_t e;
    int   k;
    bit   done;
    e.name = name; e.expData = expData; e.expCycles = expCycles; e.expWe = expWe;
    e.expWdata = wd; e.expBusErr = expBus; e.expRomErr = expRom; e.expCs = expCs;
    @(posedge clk); #1;
    reset = 1'b0;
    sbQ.push_back(e);
    cpu_address = addr; cpu_write = wr; cpu_data_o = wd;
    ram_rdata = ~rd; rom_rdata = ~rd; io_rdata = ~rd;
    if (addr < 16'hD000) ram_rdata = rd;
    else if (addr < 16'hE000) io_rdata = rd;
    else rom_rdata = rd;
    io_ack = (ackDelay == 0);
    txnActive = 1'b1;
    k = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
      io_ack = (k == ackDelay);
    end
    if (!done) begin
      checkOutput({name, "_noReady"}, 32'd0, 32'd1);
      sbQ.delete();
    end
    @(posedge clk); #1;
    txnActive = 1'b0;
    cpu_address = 16'h0000; cpu_write = 1'b0; cpu_data_o = 8'h00;
    io_ack = 1'b0; ram_rdata = 8'h3C;
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    checkOutput("reset_ready", {31'd0, cpu_ready}, 32'd1);
    checkOutput("reset_cs", {29'd0, ram_cs, rom_cs, io_cs}, 32'd0);
    checkOutput("reset_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_data", {24'd0, cpu_data_i}, 32'd0);
    checkOutput("reset_errs", {30'd0, bus_err, rom_wr_err}, 32'd0);

    //            name                 addr     wr  wd     rd    ack  data  cyc we bus rom cs
    applyStimulus("ram_read_0200",     16'h0200, 0, 8'h00, 8'h5A, -1, 8'h5A, 1, 0, 0, 0, 3'b100);
    applyStimulus("ram_write_1234",    16'h1234, 1, 8'hA7, 8'h11, -1, 8'h11, 1, 1, 0, 0, 3'b100);
    applyStimulus("ram_edge_CFFF",     16'hCFFF, 0, 8'h00, 8'h77, -1, 8'h77, 1, 0, 0, 0, 3'b100);
    applyStimulus("rom_read_FFFC",     16'hFFFC, 0, 8'h00, 8'hC3, -1, 8'hC3, 3, 0, 0, 0, 3'b010);
    applyStimulus("rom_write_E000",    16'hE000, 1, 8'h55, 8'h99, -1, 8'h99, 3, 0, 0, 1, 3'b010);
    applyStimulus("io_write_D010",     16'hD010, 1, 8'h33, 8'h44,  3, 8'h44, 4, 1, 0, 0, 3'b001);
    applyStimulus("io_read_timeout",   16'hD020, 0, 8'h00, 8'h12, -1, 8'hFF, 5, 0, 1, 0, 3'b001);
    applyStimulus("io_read_ack0_D000", 16'hD000, 0, 8'h00, 8'h6E,  0, 8'h6E, 1, 0, 0, 0, 3'b001);
    applyStimulus("io_write_ackAtTo",  16'hDFFF, 1, 8'hC8, 8'h21,  4, 8'h21, 5, 1, 0, 0, 3'b001);

    // Abandon an IO write while it sits in WAIT_IO.
    @(posedge clk); #1;
    cpu_address = 16'hD030; cpu_write = 1'b1; cpu_data_o = 8'h99; io_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset_ready", {31'd0, cpu_ready}, 32'd1);
    checkOutput("midReset_ioCs", {31'd0, io_cs}, 32'd0);
    checkOutput("midReset_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midReset_busErr", {31'd0, bus_err}, 32'd0);

    applyStimulus("io_after_reset",    16'hD030, 0, 8'h00, 8'h5F,  1, 8'h5F, 2, 0, 0, 0, 3'b001);
    applyStimulus("ram_after_reset",   16'h0000, 1, 8'h0F, 8'h81, -1, 8'h81, 1, 1, 0, 0, 3'b100);

    repeat (2) @(posedge clk);
    if (sbQ.size() != 0) checkOutput("scoreboard_leftover", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
